// File: rtl/stream_group_accumulator.sv
// Sums every n consecutive accepted items into one total and presents it on a
// valid/ready output. Accumulation of the next group continues while a total waits.
module stream_group_accumulator #(
  parameter int width = 8,
  parameter int n     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up_valid,
  output logic                         up_ready,
  input  logic [width-1:0]             up_data,
  output logic                         down_valid,
  input  logic                         down_ready,
  output logic [width+$clog2(n)-1:0]   down_data
);

  localparam int cw = $clog2(n);
  localparam int sw = width + cw;
  localparam logic [cw-1:0] cnt_last = cw'(n - 1);

  logic [sw-1:0] acc_reg;
  logic [cw-1:0] cnt_reg;
  logic          down_valid_reg;
  logic [sw-1:0] down_data_reg;

  logic          last;
  logic          up_fire;
  logic          down_fire;
  logic [sw-1:0] acc_next;

  assign last      = (cnt_reg == cnt_last);
  // Only a completing item can be refused, and only while the old total is stuck.
  assign up_ready  = ~(last & down_valid_reg & ~down_ready);
  assign up_fire   = up_valid & up_ready;
  assign down_fire = down_valid_reg & down_ready;
  assign acc_next  = acc_reg + sw'(up_data);

  assign down_valid = down_valid_reg;
  assign down_data  = down_data_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      down_valid_reg <= 1'b0;
      down_data_reg  <= '0;
    end else begin
      if (down_fire) begin
        down_valid_reg <= 1'b0;
      end
      // A completing item overrides the clear above, so back-to-back totals have no bubble.
      if (up_fire) begin
        if (last) begin
          down_data_reg  <= acc_next;
          down_valid_reg <= 1'b1;
          acc_reg        <= '0;
          cnt_reg        <= '0;
        end else begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule
